// File: rtl/fp_addsub_sched.sv
// fp_addsub_sched: shares one combinational single-precision add/sub unit
// between two requesters.
//   clk, rst            : clock and asynchronous active-high reset
//   req_valid/req_ready : per-requester handshake (bit i = requester i)
//   req_a*/req_b*/req_op: operands and operation (1 = A+B, 0 = A-B)
//   rsp_*               : registered, tagged response with flags
//   op_count            : wrapping count of completed responses
// Also contains add_sub: combinational IEEE-754 adder, round-to-nearest-even,
// subnormal inputs treated as zero, tiny results flushed to signed zero.

module add_sub (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        checkequation,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow
);
  logic        a_nan, b_nan, a_inf, b_inf, sign_a, sign_b, swap;
  logic        sign_big, sign_small, sticky, norm_sticky, round_up;
  logic [7:0]  e_big, e_small, diff;
  logic [23:0] m_big, m_small, mant;
  logic [26:0] mx, my, lost_mask;
  logic [27:0] sum;
  logic [26:0] norm;
  logic [4:0]  lz;
  logic [24:0] rounded;
  logic signed [9:0] exp_n, exp_f;
  logic [22:0] frac_f;

  // Order operands by magnitude so the subtraction never goes negative,
  // then align, add, normalise and round with guard/round/sticky bits.
  always_comb begin
    a_nan  = (&a[30:23]) && (|a[22:0]);
    b_nan  = (&b[30:23]) && (|b[22:0]);
    a_inf  = (&a[30:23]) && !(|a[22:0]);
    b_inf  = (&b[30:23]) && !(|b[22:0]);
    sign_a = a[31];
    sign_b = b[31] ^ ~checkequation;
    swap   = (b[30:0] > a[30:0]);
    sign_big   = swap ? sign_b : sign_a;
    sign_small = swap ? sign_a : sign_b;
    e_big      = swap ? b[30:23] : a[30:23];
    e_small    = swap ? a[30:23] : b[30:23];
    m_big      = (e_big != 8'd0) ? {1'b1, (swap ? b[22:0] : a[22:0])} : 24'd0;
    m_small    = (e_small != 8'd0) ? {1'b1, (swap ? a[22:0] : b[22:0])} : 24'd0;
    diff = e_big - e_small;
    mx   = {m_big, 3'b000};
    lost_mask = 27'd0;
    if (diff >= 8'd27) begin
      sticky = |m_small;
      my     = {26'd0, sticky};
    end else begin
      lost_mask = ~({27{1'b1}} << diff[4:0]);
      sticky    = |({m_small, 3'b000} & lost_mask);
      my        = ({m_small, 3'b000} >> diff[4:0]) | {26'd0, sticky};
    end
    sum = (sign_big ^ sign_small) ? ({1'b0, mx} - {1'b0, my})
                                  : ({1'b0, mx} + {1'b0, my});
    lz = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (sum[i]) lz = 5'(26 - i);
    end
    if (sum[27]) begin
      norm        = sum[27:1];
      norm_sticky = sum[0];
      exp_n       = $signed({2'b00, e_big}) + 10'sd1;
    end else begin
      norm        = sum[26:0] << lz;
      norm_sticky = 1'b0;
      exp_n       = $signed({2'b00, e_big}) - $signed({5'b00000, lz});
    end
    mant     = norm[26:3];
    round_up = norm[2] & (norm[1] | norm[0] | norm_sticky | mant[0]);
    rounded  = {1'b0, mant} + {24'd0, round_up};
    // A rounding carry leaves the mantissa as 1.000..0 one exponent higher.
    if (rounded[24]) begin
      exp_f  = exp_n + 10'sd1;
      frac_f = rounded[23:1];
    end else begin
      exp_f  = exp_n;
      frac_f = rounded[22:0];
    end
    result    = 32'd0;
    overflow  = 1'b0;
    underflow = 1'b0;
    if (a_nan || b_nan) begin
      result = 32'h7FC0_0000;
    end else if (a_inf || b_inf) begin
      if (a_inf && b_inf && (sign_a != sign_b)) result = 32'h7FC0_0000;
      else result = {(a_inf ? sign_a : sign_b), 8'hFF, 23'd0};
    end else if (sum == 28'd0) begin
      result = 32'd0;
    end else if (exp_f >= 10'sd255) begin
      result   = {sign_big, 8'hFF, 23'd0};
      overflow = 1'b1;
    end else if (exp_f <= 10'sd0) begin
      result    = {sign_big, 31'd0};
      underflow = 1'b1;
    end else begin
      result = {sign_big, exp_f[7:0], frac_f};
    end
  end
endmodule

module fp_addsub_sched #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [31:0]      req_a0,
  input  logic [31:0]      req_b0,
  input  logic [31:0]      req_a1,
  input  logic [31:0]      req_b1,
  input  logic [1:0]       req_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [31:0]      rsp_result,
  output logic             rsp_overflow,
  output logic             rsp_underflow,
  output logic             rsp_nan,
  output logic [CNT_W-1:0] op_count
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t      state, next_state;
  logic        prio, grant, accept, lat_op, lat_id, lat_nan;
  logic [31:0] lat_a, lat_b, as_result;
  logic        as_overflow, as_underflow;

  add_sub u_add_sub (
    .a(lat_a), .b(lat_b), .checkequation(lat_op),
    .result(as_result), .overflow(as_overflow), .underflow(as_underflow)
  );

  assign lat_nan   = ((&lat_a[30:23]) && (|lat_a[22:0])) ||
                     ((&lat_b[30:23]) && (|lat_b[22:0]));
  assign accept    = |req_ready;
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Grant only in IDLE; prio breaks ties when both requesters are valid.
  always_comb begin
    next_state = state;
    grant      = 1'b0;
    req_ready  = 2'b00;
    case (state)
      IDLE: begin
        grant = (req_valid == 2'b11) ? prio : req_valid[1];
        if (req_valid[grant] && !rst) begin
          req_ready[grant] = 1'b1;
          next_state       = EXEC;
        end
      end
      EXEC: next_state = RESP;
      RESP: if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio          <= 1'b0;
      lat_a         <= 32'd0;
      lat_b         <= 32'd0;
      lat_op        <= 1'b0;
      lat_id        <= 1'b0;
      rsp_id        <= 1'b0;
      rsp_result    <= 32'd0;
      rsp_overflow  <= 1'b0;
      rsp_underflow <= 1'b0;
      rsp_nan       <= 1'b0;
      op_count      <= '0;
    end else begin
      if (accept) begin
        lat_a  <= grant ? req_a1 : req_a0;
        lat_b  <= grant ? req_b1 : req_b0;
        lat_op <= req_op[grant];
        lat_id <= grant;
        prio   <= ~grant;
      end
      // Any NaN operand forces the canonical quiet NaN and masks the flags.
      if (state == EXEC) begin
        rsp_id        <= lat_id;
        rsp_result    <= lat_nan ? 32'h7FC0_0000 : as_result;
        rsp_overflow  <= lat_nan ? 1'b0 : as_overflow;
        rsp_underflow <= lat_nan ? 1'b0 : as_underflow;
        rsp_nan       <= lat_nan;
      end
      if ((state == RESP) && rsp_ready) op_count <= op_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_fp_addsub_sched.sv
// tb_fp_addsub_sched: drives both requesters of fp_addsub_sched and compares
// every response with a real-arithmetic IEEE-754 reference model.
module tb_fp_addsub_sched;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, req_ready2, req_op;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic        rsp_ready;
  logic        rsp_valid, rsp_id, rsp_overflow, rsp_underflow, rsp_nan;
  logic [31:0] rsp_result;
  logic [15:0] op_count;
  logic        rsp_valid2, rsp_id2, rsp_overflow2, rsp_underflow2, rsp_nan2;
  logic [31:0] rsp_result2;
  logic [1:0]  op_count2;
  int checks = 0;
  int errors = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  fp_addsub_sched #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_op(req_op), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_overflow(rsp_overflow),
    .rsp_underflow(rsp_underflow), .rsp_nan(rsp_nan), .op_count(op_count)
  );

  fp_addsub_sched #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready2),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_op(req_op), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id2), .rsp_result(rsp_result2), .rsp_overflow(rsp_overflow2),
    .rsp_underflow(rsp_underflow2), .rsp_nan(rsp_nan2), .op_count(op_count2)
  );

  function automatic real pow2(input int n);
    real p = 1.0;
    if (n >= 0) for (int i = 0; i < n; i++) p = p * 2.0;
    else        for (int i = 0; i < -n; i++) p = p / 2.0;
    return p;
  endfunction

  function automatic real to_real(input logic [31:0] x);
    real v;
    if (x[30:23] == 8'd0) return 0.0;
    v = (1.0 + real'(x[22:0]) / 8388608.0) * pow2(int'(x[30:23]) - 127);
    return x[31] ? -v : v;
  endfunction

  // Returns {nan, overflow, underflow, result}: exact sum rounded to nearest even.
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic op);
    logic an, bn, ai, bi, sb, s;
    real r, m, p, scaled, fr;
    int e;
    longint q;
    an = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    if (an || bn) return {3'b100, 32'h7FC0_0000};
    sb = b[31] ^ ~op;
    ai = (a[30:23] == 8'hFF);
    bi = (b[30:23] == 8'hFF);
    if (ai || bi) begin
      if (ai && bi && (a[31] != sb)) return {3'b000, 32'h7FC0_0000};
      return {3'b000, (ai ? a[31] : sb), 8'hFF, 23'd0};
    end
    r = op ? (to_real(a) + to_real(b)) : (to_real(a) - to_real(b));
    if (r == 0.0) return 35'd0;
    s = (r < 0.0);
    m = s ? -r : r;
    e = 0;
    p = 1.0;
    while (m >= 2.0 * p) begin p = p * 2.0; e++; end
    while (m < p) begin p = p / 2.0; e--; end
    scaled = m / p * 8388608.0;
    fr = scaled - $floor(scaled);
    q = longint'($floor(scaled));
    if (fr > 0.5 || (fr == 0.5 && q[0])) q++;
    if (q == 64'd16777216) begin q = 64'd8388608; e++; end
    if (e + 127 >= 255) return {3'b010, s, 8'hFF, 23'd0};
    if (e + 127 <= 0)   return {3'b001, s, 31'd0};
    return {3'b000, s, 8'(e + 127), q[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp(input int base);
    int e;
    if ($urandom_range(0, 15) == 0) return 32'd0;
    e = base + int'($urandom_range(0, 12));
    if (e > 254) e = 254;
    return {1'($urandom_range(0, 1)), 8'(e), 23'($urandom)};
  endfunction

  function automatic int rand_base();
    int sel = int'($urandom_range(0, 3));
    if (sel == 0) return 1;
    if (sel == 1) return 242;
    return 120;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    exp_count = 0;
  endtask

  task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic op, output bit ok);
    int waited = 0;
    @(negedge clk);
    if (id == 0) begin req_a0 = a; req_b0 = b; end
    else begin req_a1 = a; req_b1 = b; end
    req_op[id] = op;
    req_valid[id] = 1'b1;
    ok = 1'b0;
    #1;
    while (!ok && waited < 20) begin
      if (req_ready[id]) ok = 1'b1;
      else begin @(negedge clk); #1; waited++; end
    end
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic collect(output logic [35:0] got, output int edges, output bit ok);
    edges = 0;
    ok = 1'b0;
    while (!ok && edges < 20) begin
      @(posedge clk); #1;
      edges++;
      if (rsp_valid) ok = 1'b1;
    end
    got = {rsp_id, rsp_nan, rsp_overflow, rsp_underflow, rsp_result};
  endtask

  task automatic drain();
    @(posedge clk); #1;
    exp_count++;
  endtask

  task automatic run_checked(input string name, input int id, input logic [31:0] a,
                             input logic [31:0] b, input logic op,
                             input logic [34:0] expv);
    bit ok, ok2;
    int edges;
    logic [35:0] got;
    issue(id, a, b, op, ok);
    collect(got, edges, ok2);
    checks++;
    if (!(ok && ok2)) begin
      errors++;
      $display("[TB] FAIL %s handshake timeout: accept=%0d rsp=%0d required 1 1", name, ok, ok2);
    end
    checks++;
    if (edges + 1 !== 2) begin
      errors++;
      $display("[TB] FAIL %s latency: got %0d edges required 2", name, edges + 1);
    end
    checks++;
    if (got !== {1'(id), expv}) begin
      errors++;
      $display("[TB] FAIL %s a=%h b=%h op=%0d: got id/nan/ov/un/res=%h required %h",
               name, a, b, op, got, {1'(id), expv});
    end
    drain();
  endtask

  task automatic test_reset();
    req_valid = 2'b11;
    rst = 1'b1;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_id, rsp_nan, rsp_overflow, rsp_underflow,
         rsp_result, op_count} !== 55'd0) begin
      errors++;
      $display("[TB] FAIL reset_values: got ready=%b valid=%b id=%b res=%h cnt=%0d required all 0",
               req_ready, rsp_valid, rsp_id, rsp_result, op_count);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b00 || rsp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_hold: got ready=%b valid=%b required 00 0", req_ready, rsp_valid);
    end
    req_valid = 2'b00;
    rst = 1'b0;
    exp_count = 0;
  endtask

  task automatic test_single_add();
    run_checked("single_add", 0, 32'h3F80_0000, 32'h4000_0000, 1'b1, {3'b000, 32'h4040_0000});
    checks++;
    if (op_count !== 16'd1) begin
      errors++;
      $display("[TB] FAIL single_add_count: got %0d required 1", op_count);
    end
  endtask

  task automatic test_sub_req1();
    run_checked("sub_req1", 1, 32'h4040_0000, 32'h3F80_0000, 1'b0, {3'b000, 32'h4000_0000});
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int id = int'($urandom_range(0, 1));
      int base = rand_base();
      logic [31:0] a = rand_fp(base);
      logic [31:0] b = rand_fp(base);
      logic op = 1'($urandom_range(0, 1));
      run_checked("random", id, a, b, op, model(a, b, op));
    end
    checks++;
    if (op_count !== 16'(exp_count)) begin
      errors++;
      $display("[TB] FAIL random_count: got %0d required %0d", op_count, exp_count);
    end
  endtask

  task automatic test_nan_inf();
    logic [31:0] va [8] = '{32'h404C_AC08, 32'h7F80_0000, 32'h7F80_0000, 32'h7F7F_FFFF,
                            32'h0080_0001, 32'h7FC0_0001, 32'hFF80_0000, 32'h3F80_0000};
    logic [31:0] vb [8] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h7F80_0000, 32'h7F7F_FFFF,
                            32'h0080_0000, 32'h3F80_0000, 32'h7F80_0000, 32'h3F80_0000};
    logic        vo [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [34:0] ve [8] = '{{3'b100, 32'h7FC0_0000}, {3'b000, 32'h7F80_0000},
                            {3'b000, 32'h7FC0_0000}, {3'b010, 32'h7F80_0000},
                            {3'b001, 32'h0000_0000}, {3'b100, 32'h7FC0_0000},
                            {3'b000, 32'hFF80_0000}, {3'b000, 32'h0000_0000}};
    for (int k = 0; k < 8; k++) run_checked("nan_inf", k % 2, va[k], vb[k], vo[k], ve[k]);
  endtask

  task automatic test_contention();
    logic [35:0] q[$];
    logic [35:0] front;
    logic [31:0] a0, b0, a1, b1;
    logic o0, o1, prev_acc, gid;
    int grants = 0;
    int seen = 0;
    int cyc = 0;
    do_reset();
    a0 = rand_fp(120); b0 = rand_fp(120); o0 = 1'($urandom_range(0, 1));
    a1 = rand_fp(120); b1 = rand_fp(120); o1 = 1'($urandom_range(0, 1));
    @(negedge clk);
    req_a0 = a0; req_b0 = b0; req_a1 = a1; req_b1 = b1; req_op = {o1, o0};
    req_valid = 2'b11;
    prev_acc = 1'b0;
    while (cyc < 60 && seen < 4) begin
      if (cyc > 0) @(negedge clk);
      if (grants == 4) req_valid = 2'b00;
      #1;
      cyc++;
      checks++;
      if (req_ready == 2'b11 || (req_ready != 2'b00 && (rsp_valid || prev_acc))) begin
        errors++;
        $display("[TB] FAIL contention_ready: got ready=%b rsp_valid=%b prev_acc=%b required exclusive IDLE-only",
                 req_ready, rsp_valid, prev_acc);
      end
      prev_acc = (req_ready != 2'b00);
      if (req_ready != 2'b00) begin
        gid = req_ready[1];
        checks++;
        if (gid !== 1'(grants % 2)) begin
          errors++;
          $display("[TB] FAIL contention_order: grant %0d got %0d required %0d", grants, gid, grants % 2);
        end
        q.push_back({gid, (gid ? model(a1, b1, o1) : model(a0, b0, o0))});
        grants++;
      end
      if (rsp_valid && q.size() > 0) begin
        front = q.pop_front();
        checks++;
        if ({rsp_id, rsp_nan, rsp_overflow, rsp_underflow, rsp_result} !== front) begin
          errors++;
          $display("[TB] FAIL contention_rsp: got %h required %h",
                   {rsp_id, rsp_nan, rsp_overflow, rsp_underflow, rsp_result}, front);
        end
        seen++;
      end
    end
    req_valid = 2'b00;
    checks++;
    if (grants !== 4 || seen !== 4) begin
      errors++;
      $display("[TB] FAIL contention_count: got grants=%0d rsp=%0d required 4 4", grants, seen);
    end
    @(posedge clk); #1;
    exp_count += 4;
  endtask

  task automatic test_backpressure();
    bit ok, ok2;
    int edges;
    logic [35:0] snap, got;
    logic [15:0] cnt0;
    logic [31:0] a = rand_fp(120);
    logic [31:0] b = rand_fp(120);
    rsp_ready = 1'b0;
    issue(0, a, b, 1'b1, ok);
    req_a1 = rand_fp(120); req_b1 = rand_fp(120);
    req_valid[1] = 1'b1;
    collect(snap, edges, ok2);
    cnt0 = op_count;
    checks++;
    if (!(ok && ok2) || snap !== {1'b0, model(a, b, 1'b1)}) begin
      errors++;
      $display("[TB] FAIL backpressure_rsp: got %h required %h", snap, {1'b0, model(a, b, 1'b1)});
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      got = {rsp_id, rsp_nan, rsp_overflow, rsp_underflow, rsp_result};
      checks++;
      if (got !== snap || req_ready !== 2'b00 || op_count !== cnt0 || rsp_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL backpressure_hold: got rsp=%h ready=%b cnt=%0d valid=%b required %h 00 %0d 1",
                 got, req_ready, op_count, rsp_valid, snap, cnt0);
      end
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    exp_count++;
    checks++;
    if (rsp_valid !== 1'b0 || op_count !== cnt0 + 16'd1) begin
      errors++;
      $display("[TB] FAIL backpressure_release: got valid=%b cnt=%0d required 0 %0d",
               rsp_valid, op_count, cnt0 + 16'd1);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || op_count !== cnt0 + 16'd1) begin
      errors++;
      $display("[TB] FAIL backpressure_single: got valid=%b cnt=%0d required 0 %0d",
               rsp_valid, op_count, cnt0 + 16'd1);
    end
  endtask

  task automatic test_reset_mid_exec();
    bit ok;
    bit leaked = 1'b0;
    issue(1, 32'h3F80_0000, 32'h3F80_0000, 1'b1, ok);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (!ok || {req_ready, rsp_valid, rsp_id, rsp_nan, rsp_overflow, rsp_underflow,
                rsp_result, op_count} !== 55'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid_exec: got accept=%0d valid=%b res=%h cnt=%0d required 1 0 0 0",
               ok, rsp_valid, rsp_result, op_count);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_count = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rsp_valid) leaked = 1'b1;
    end
    checks++;
    if (leaked || op_count !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_no_escape: got leaked=%0d cnt=%0d required 0 0", leaked, op_count);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int n = 0; n < 5; n++) begin
      logic [31:0] a = rand_fp(120);
      logic [31:0] b = rand_fp(120);
      run_checked("wrap_op", n % 2, a, b, 1'b1, model(a, b, 1'b1));
    end
    checks++;
    if (op_count2 !== 2'd1 || op_count !== 16'd5) begin
      errors++;
      $display("[TB] FAIL wrap_count: got cnt2=%0d cnt16=%0d required 1 5", op_count2, op_count);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 2'b00;
    req_op = 2'b00;
    req_a0 = 32'd0; req_b0 = 32'd0; req_a1 = 32'd0; req_b1 = 32'd0;
    rsp_ready = 1'b1;
    test_reset();
    test_single_add();
    test_sub_req1();
    test_random();
    test_nan_inf();
    test_contention();
    test_backpressure();
    test_reset_mid_exec();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_addsub_sched.md
# fp_addsub_sched

Two-requester scheduler that shares one combinational `add_sub` single-precision adder/subtractor between two independent clients. It arbitrates round-robin, captures operands, runs the shared unit for one cycle, and returns a registered, tagged response with overflow, underflow and NaN flags. It also canonicalises NaN results and keeps a wrapping count of completed operations. It sits between the calculator front-end sequencers and the `add_sub` datapath. `add_sub` is instantiated inside this block.

## Interface
- `CNT_W`, default 16: width of the completed-operation counter.
- `clk`  input  1: sole clock; all state updates on the rising edge.
- `rst`  input  1: one clock; reset is asynchronous and active-high.
- `req_valid`  input  2: bit i is high when requester i presents an operation.
- `req_ready`  output  2: bit i is high when requester i's operation is accepted this cycle.
- `req_a0`, `req_b0`  input  32: IEEE-754 operands A and B from requester 0.
- `req_a1`, `req_b1`  input  32: IEEE-754 operands A and B from requester 1.
- `req_op`  input  2: bit i is requester i's operation. 1 means A+B, 0 means A−B. The bit is forwarded unchanged to `add_sub.checkequation`.
- `rsp_valid`  output  1: response available.
- `rsp_ready`  input  1: consumer accepts the response.
- `rsp_id`  output  1: index of the requester that owns the response.
- `rsp_result`  output  32: result.
- `rsp_overflow`, `rsp_underflow`  output  1: flags from `add_sub`.
- `rsp_nan`  output  1: at least one operand was a NaN.
- `op_count`  output  `CNT_W`: number of completed responses, wrapping.

## Operation
- The FSM has three states: IDLE, EXEC and RESP. Reset state is IDLE.
- **IDLE**
  - The grant goes to the requester with valid high.
  - If both are valid, the grant goes to the requester pointed to by the priority pointer `prio`.
  - `req_ready[grant]` is asserted combinationally. The other ready bit is 0.
  - On the edge where valid and ready are both high, the block does three things:
    - latches A, B, op and id;
    - sets `prio` to the other requester;
    - moves to EXEC.
- **EXEC**
  - The latched operands drive `add_sub`.
  - At the end of the cycle the result, overflow and underflow are registered into the `rsp_*` registers.
  - The state moves to RESP.
- **RESP**
  - `rsp_valid` is 1.
  - On the edge where `rsp_valid` and `rsp_ready` are both high:
    - `op_count` increments, wrapping from 2^CNT_W−1 to 0;
    - the state returns to IDLE.
  - `req_ready` is 0 in EXEC and in RESP. There is exactly one operation in flight.
- **NaN rule**
  - An operand is NaN when its exponent is 0xFF and its mantissa is non-zero.
  - If either latched operand is NaN:
    - `rsp_result` = 0x7FC00000;
    - `rsp_nan` = 1;
    - `rsp_overflow` = 0 and `rsp_underflow` = 0.
  - Otherwise `rsp_result` and both flags come from `add_sub` unmodified, and `rsp_nan` = 0.
- **Response stability**: `rsp_*` values are stable for as long as `rsp_valid` is high.
- **Requester holding rules**
  - A requester must hold its valid and operands until ready is seen.
  - A requester may drop valid without penalty before it is granted.
  - A requester is never granted while its valid is low.
- **Reset values**
  - `rsp_valid`, `rsp_id`, `rsp_result`, all flags and `op_count` reset to 0.
  - `req_ready` is 0 during reset.
  - `prio` resets to requester 0.
- **Reset mid-operation**: asserting `rst` in EXEC or RESP discards the in-flight operation, clears all state to reset values, and lets no response escape.

## Timing
- Acceptance edge T: the edge with valid and ready both high.
- EXEC occupies the cycle after T.
- `rsp_valid` rises after edge T+1 and is visible in cycle T+1..T+2. Request to response is 2 clock edges.
- With `rsp_ready` held high, minimum initiation interval is 3 cycles per operation: IDLE, EXEC, RESP.
- If `rsp_ready` is low, the block stalls in RESP indefinitely with no data change.
- The `op_count` update and the return to IDLE happen on the same edge as the handshake.
- The next grant can happen in the first IDLE cycle after the handshake.
- Simultaneous requests while `prio`=0 are granted in the order 0, 1, 0, 1…. Neither requester waits more than one competing operation.

## Test plan
- **Single add**: requester 0, op=1, A=0x3F800000, B=0x40000000, `rsp_ready`=1.
  - Response: `rsp_result`=0x40400000, `rsp_id`=0, no flags.
  - `rsp_valid` appears 2 edges after acceptance; `op_count`=1 after the handshake.
- **Subtract on requester 1**: op=0, A=0x40400000, B=0x3F800000.
  - Response: `rsp_result`=0x40000000, `rsp_id`=1.
- **Contention**: both requesters valid continuously for 4 operations after reset.
  - Grants go 0, 1, 0, 1.
  - `req_ready` is never high for both bits in the same cycle, and is never high outside IDLE.
- **Backpressure**: hold `rsp_ready`=0 for 5 cycles in RESP.
  - `rsp_*` stays constant, `req_ready` stays 0, `op_count` is unchanged.
  - On release: exactly one handshake, and `op_count` increments by 1.
- **NaN and infinity**
  - A=0x404CAC08, B=0xFFFFFFFF: `rsp_result`=0x7FC00000, `rsp_nan`=1, overflow=0, underflow=0.
  - A=0x7F800000, B=0x00000000, op=1: `rsp_nan`=0, result and flags equal to `add_sub`'s outputs.
- **Reset and wrap**
  - Assert `rst` mid-EXEC: all outputs return to 0 asynchronously, and no `rsp_valid` pulse appears afterwards.
  - With `CNT_W`=2, 5 completions: `op_count` reads 1.
